shift_register_rx: RTL and testbench
====================================

// Module: shift_register_rx
// PURPOSE
//  Serial-to-parallel receiver; the receiving end of the serial bit stream that
//  shift_register emits on MSB_out/LSB_out.
//  - Samples bit_in on each bit_valid strobe and assembles WIDTH-bit words in
//    MSB-first or LSB-first order.
//  - Presents each completed word on a valid/ready output port.
//  - The output holding register is separate from the shift register, so the
//    next word can be received while the current one waits for the consumer.
// PARAMETERS
//  WIDTH  16  word length in bits; legal values >= 2
//  CNT_W  5   bit_count width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk         in   1      clock; all logic on the rising edge
//  reset_n     in   1      asynchronous active-low reset
//  bit_in      in   1      serial data bit
//  bit_valid   in   1      bit_in is sampled on every clk edge where this is 1
//  lsb_first   in   1      1 = LSB-first, 0 = MSB-first; sampled on a word's first bit only
//  clear       in   1      synchronous abort
//  data_out    out  WIDTH  received word
//  data_valid  out  1      data_out holds an unconsumed word
//  data_ready  in   1      consumer accepts data_out when data_valid && data_ready
//  busy        out  1      a word is partially received (state != IDLE)
//  bit_count   out  CNT_W  number of data bits received for the current word
//  overrun     out  1      sticky: a completed word was dropped
// BEHAVIOUR
//  - Reset (reset_n=0, asynchronous): state=IDLE; shift reg, data_out,
//    bit_count = 0; data_valid, overrun, busy = 0. Reset mid-word drops the word.
//  - Priority: reset_n > clear > normal operation. clear=1 forces IDLE, drops any
//    partial word, zeroes bit_count, clears data_valid and overrun. data_out keeps its value.
//  - FSM states: IDLE, SHIFT, PAR. PAR exists only with the optional feature.
//  - IDLE: on bit_valid, latch lsb_first into dir, shift in the bit,
//    bit_count=1, go to SHIFT.
//  - SHIFT, on each bit_valid:
//    - MSB-first: sr <= {sr[WIDTH-2:0], bit_in}
//    - LSB-first: sr <= {bit_in, sr[WIDTH-1:1]}
//    - bit_count++. Cycles without bit_valid hold all state; gaps are unlimited.
//  - Word completion: the bit_valid that brings bit_count to WIDTH completes the word.
//    - The word transfers to data_out and bit_count returns to 0.
//    - Next state is IDLE, or PAR when the option is enabled.
//    - data_valid rises on the clk edge that samples the final bit.
//      It is observable in the cycle after that bit is presented (latency = 1 clk).
//  - Transfer rule: the completed word is written when the slot is free,
//    i.e. !data_valid, or data_valid && data_ready in that same cycle.
//    - Completion and acceptance in the same cycle: the new word loads and
//      data_valid stays 1.
//    - Otherwise the new word is dropped and overrun is set; data_out is unchanged.
//  - Consumer side: data_valid is held until accepted and falls on the accept
//    edge unless a new word loads on that edge.
//  - dir is fixed for the whole word; lsb_first changes mid-word are ignored.
//  - busy = (state != IDLE).
// CONFIGURATION
//  `define SHIFT_RX_PARITY_EN
//  - Defined:
//    - After the WIDTH data bits the FSM enters PAR; the next bit_valid bit is
//      the parity bit, and the FSM then returns to IDLE.
//    - The data word is transferred when the parity bit is sampled, not
//      when the last data bit is sampled.
//    - Adds output parity_err (1 bit) = XOR of the WIDTH data bits and the parity
//      bit; nonzero means an even-parity failure.
//    - parity_err is registered together with data_out, is valid while
//      data_valid=1, and resets to 0. clear also resets it to 0.
//    - busy stays 1 in PAR.
//  - Not defined: PAR state and parity_err port do not exist; words complete
//    on the WIDTH-th bit.
// TESTING
//  1. MSB-first, lsb_first=0, 16 back-to-back bits of 16'hA5C3 (MSB first), data_ready=1
//     -> data_valid=1 for 1 cycle after the last bit with data_out=16'hA5C3; overrun=0.
//  2. LSB-first, lsb_first=1, same bit sequence as test 1 -> data_out=16'hC3A5
//     (bit-reversed); lsb_first toggled mid-word has no effect.
//  3. Random 0-5 cycle gaps in bit_valid while sending 16'h0001 -> data_out=16'h0001;
//     bit_count increments only on bit_valid; busy=1 from first to last bit.
//  4. data_ready=0; send 16'h1111 then 16'h2222 -> data_out=16'h1111, overrun=1;
//     then data_ready=1 on the 16'h3333 completion cycle -> data_out=16'h3333, data_valid=1.
//  5. clear after 7 bits, then a full 16'hBEEF -> 16'hBEEF; repeat with reset_n
//     pulsed low mid-word -> all outputs 0 at once, the next word is clean.
//  6. PARITY_EN: 16'h0003 + parity 0 -> parity_err=0; 16'h0007 + parity 0 -> parity_err=1.

Source files
------------

// File: rtl/shift_register_rx.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from a bit_valid-strobed stream.
// Optional trailing even-parity bit and parity_err output when SHIFT_RX_PARITY_EN is defined.
module shift_register_rx #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             lsb_first,
  input  logic             clear,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun
`ifdef SHIFT_RX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef SHIFT_RX_PARITY_EN
    ,
    PAR
`endif
  } state_t;

  state_t           state, state_n;
  logic             dir, dir_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [CNT_W-1:0] cnt_n;
  logic [WIDTH-1:0] dout_n;
  logic             dv_n, ovr_n;
  logic             accept, complete;
  logic [WIDTH-1:0] word;
`ifdef SHIFT_RX_PARITY_EN
  logic             perr_n, par_bit;
`endif

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v,
                                                input logic b, input logic lsb);
    return lsb ? {b, v[WIDTH-1:1]} : {v[WIDTH-2:0], b};
  endfunction

  assign busy   = (state != IDLE);
  assign accept = data_valid && data_ready;

  always_comb begin
    state_n  = state;
    dir_n    = dir;
    sr_n     = sr;
    cnt_n    = bit_count;
    dout_n   = data_out;
    dv_n     = data_valid;
    ovr_n    = overrun;
    complete = 1'b0;
    word     = sr;
`ifdef SHIFT_RX_PARITY_EN
    perr_n   = parity_err;
    par_bit  = 1'b0;
`endif
    if (clear) begin
      state_n = IDLE;
      sr_n    = '0;
      cnt_n   = '0;
      dv_n    = 1'b0;
      ovr_n   = 1'b0;
`ifdef SHIFT_RX_PARITY_EN
      perr_n  = 1'b0;
`endif
    end else begin
      if (accept) dv_n = 1'b0;
      if (bit_valid) begin
        case (state)
          IDLE: begin
            // Direction is captured from the first bit and frozen for the word.
            dir_n   = lsb_first;
            sr_n    = shift_in(sr, bit_in, lsb_first);
            cnt_n   = CNT_W'(1);
            state_n = SHIFT;
          end
          SHIFT: begin
            sr_n = shift_in(sr, bit_in, dir);
            if (bit_count == CNT_W'(WIDTH - 1)) begin
`ifdef SHIFT_RX_PARITY_EN
              cnt_n   = CNT_W'(WIDTH);
              state_n = PAR;
`else
              cnt_n    = '0;
              state_n  = IDLE;
              complete = 1'b1;
              word     = sr_n;
`endif
            end else begin
              cnt_n = bit_count + 1'b1;
            end
          end
`ifdef SHIFT_RX_PARITY_EN
          PAR: begin
            complete = 1'b1;
            word     = sr;
            par_bit  = bit_in;
            cnt_n    = '0;
            state_n  = IDLE;
          end
`endif
          default: state_n = IDLE;
        endcase
      end
      // A finished word lands only if the holding slot is free or being freed now.
      if (complete) begin
        if (!data_valid || accept) begin
          dout_n = word;
          dv_n   = 1'b1;
`ifdef SHIFT_RX_PARITY_EN
          perr_n = (^word) ^ par_bit;
`endif
        end else begin
          ovr_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      dir        <= 1'b0;
      sr         <= '0;
      bit_count  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
`ifdef SHIFT_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      dir        <= dir_n;
      sr         <= sr_n;
      bit_count  <= cnt_n;
      data_out   <= dout_n;
      data_valid <= dv_n;
      overrun    <= ovr_n;
`ifdef SHIFT_RX_PARITY_EN
      parity_err <= perr_n;
`endif
    end
  end

endmodule

// File: tb/tb_shift_register_rx.sv
// Bench for shift_register_rx: queue-based word model compared every cycle, plus literal checks.
// Honours SHIFT_RX_PARITY_EN to exercise the parity bit and parity_err.
module tb_shift_register_rx;
  localparam int W = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset_n, bit_in, bit_valid, lsb_first, clear, data_ready;
  logic [W-1:0]  data_out;
  logic          data_valid, busy, overrun;
  logic [CW-1:0] bit_count;
`ifdef SHIFT_RX_PARITY_EN
  logic          parity_err;
`endif

  shift_register_rx #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .lsb_first(lsb_first), .clear(clear), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready), .busy(busy),
    .bit_count(bit_count), .overrun(overrun)
`ifdef SHIFT_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  // Reference: bits received so far for the current word, plus the holding slot.
  bit           mbits[$];
  logic         mdir, in_par;
  logic [W-1:0] mdo;
  logic         mdv, movr, mperr;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mbits.delete();
    mdir = 0; in_par = 0; mdo = '0; mdv = 0; movr = 0; mperr = 0;
  endtask

  task automatic model_complete(input logic accept, input logic par, output logic loaded);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++)
      if (mdir) w[i] = mbits[i]; else w[W-1-i] = mbits[i];
    mbits.delete();
    loaded = 0;
    if (!mdv || accept) begin
      mdo = w; mperr = (^w) ^ par; loaded = 1;
    end else begin
      movr = 1;
    end
  endtask

  task automatic model_update();
    logic accept, loaded;
    if (!reset_n) begin
      model_reset();
    end else if (clear) begin
      mbits.delete(); in_par = 0; mdv = 0; movr = 0; mperr = 0;
    end else begin
      accept = mdv && data_ready;
      loaded = 0;
      if (bit_valid) begin
        if (in_par) begin
          in_par = 0;
          model_complete(accept, bit_in, loaded);
        end else begin
          if (mbits.size() == 0) mdir = lsb_first;
          mbits.push_back(bit_in);
          if (mbits.size() == W) begin
`ifdef SHIFT_RX_PARITY_EN
            in_par = 1;
`else
            model_complete(accept, 1'b0, loaded);
`endif
          end
        end
      end
      if (loaded) mdv = 1;
      else if (accept) mdv = 0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("data_out", 32'(data_out), 32'(mdo));
      cmp("data_valid", 32'(data_valid), 32'(mdv));
      cmp("busy", 32'(busy), 32'(mbits.size() > 0 || in_par));
      cmp("bit_count", 32'(bit_count), 32'(mbits.size()));
      cmp("overrun", 32'(overrun), 32'(movr));
`ifdef SHIFT_RX_PARITY_EN
      cmp("parity_err", 32'(parity_err), 32'(mperr));
`endif
    end
  end

  function automatic logic pick(input int r);
    return (r == 2) ? logic'($urandom_range(0, 1)) : (r != 0);
  endfunction

  task automatic step(input logic bv, input logic b, input logic lsb, input logic clr, input logic rdy);
    @(negedge clk); #1;
    bit_valid = bv; bit_in = b; lsb_first = lsb; clear = clr; data_ready = rdy;
    @(posedge clk); #1;
    model_update();
  endtask

  // Sends a word's bits in MSB-to-LSB order; rdy/rdy_last: 0, 1 or 2 (random).
  task automatic send_word(input logic [W-1:0] word, input logic lsb, input bit toggle,
                           input int maxgap, input int rdy, input int rdy_last, input logic par);
    bit last;
    for (int n = 0; n < W; n++) begin
      repeat ($urandom_range(0, maxgap)) step(0, 0, logic'($urandom_range(0, 1)), 0, pick(rdy));
`ifdef SHIFT_RX_PARITY_EN
      last = 0;
`else
      last = (n == W - 1);
`endif
      step(1, word[W-1-n], (toggle && n > 0) ? logic'($urandom_range(0, 1)) : lsb, 0,
           pick(last ? rdy_last : rdy));
    end
`ifdef SHIFT_RX_PARITY_EN
    repeat ($urandom_range(0, maxgap)) step(0, 0, 0, 0, pick(rdy));
    step(1, par, 0, 0, pick(rdy_last));
`endif
  endtask

  initial begin
    reset_n = 0; bit_in = 0; bit_valid = 0; lsb_first = 0; clear = 0; data_ready = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_data_out", 32'(data_out), 32'h0);
    cmp("reset_bit_count", 32'(bit_count), 32'h0);
    cmp("reset_busy", 32'(busy), 32'h0);
    reset_n = 1;
    chk_en = 1;

    // MSB-first back-to-back, one-cycle valid after the final bit
    send_word(16'hA5C3, 0, 0, 0, 1, 1, 0);
    cmp("t1_data_out", 32'(data_out), 32'hA5C3);
    cmp("t1_valid", 32'(data_valid), 32'h1);
    cmp("t1_overrun", 32'(overrun), 32'h0);
    step(0, 0, 0, 0, 1);
    cmp("t1_valid_drop", 32'(data_valid), 32'h0);

    // LSB-first with lsb_first toggled after the first bit
    send_word(16'hA5C3, 1, 1, 0, 1, 1, 0);
    cmp("t2_data_out", 32'(data_out), 32'hC3A5);
    step(0, 0, 0, 0, 1);

    // Random gaps
    send_word(16'h0001, 0, 0, 5, 1, 1, 0);
    cmp("t3_data_out", 32'(data_out), 32'h0001);
    step(0, 0, 0, 0, 1);

    // Backpressure, overrun, then accept-and-load in the same cycle
    send_word(16'h1111, 0, 0, 0, 0, 0, 0);
    send_word(16'h2222, 0, 0, 0, 0, 0, 0);
    cmp("t4_data_out", 32'(data_out), 32'h1111);
    cmp("t4_overrun", 32'(overrun), 32'h1);
    send_word(16'h3333, 0, 0, 0, 0, 1, 0);
    cmp("t4_data_out2", 32'(data_out), 32'h3333);
    cmp("t4_valid", 32'(data_valid), 32'h1);
    step(0, 0, 0, 0, 1);

    // Clear mid-word, then a clean word
    for (int i = 0; i < 7; i++) step(1, logic'($urandom_range(0, 1)), 0, 0, 1);
    step(0, 0, 0, 1, 1);
    cmp("t5_clr_count", 32'(bit_count), 32'h0);
    cmp("t5_clr_overrun", 32'(overrun), 32'h0);
    send_word(16'hBEEF, 0, 0, 0, 1, 1, 0);
    cmp("t5_data_out", 32'(data_out), 32'hBEEF);

    // Asynchronous reset mid-word
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
    #1 reset_n = 0;
    #1;
    cmp("t5_rst_data_out", 32'(data_out), 32'h0);
    cmp("t5_rst_valid", 32'(data_valid), 32'h0);
    cmp("t5_rst_busy", 32'(busy), 32'h0);
    cmp("t5_rst_count", 32'(bit_count), 32'h0);
    model_reset();
    step(0, 0, 0, 0, 0);
    reset_n = 1;
    send_word(16'h1234, 0, 0, 0, 1, 1, 0);
    cmp("t5_after_rst", 32'(data_out), 32'h1234);
    step(0, 0, 0, 0, 1);

`ifdef SHIFT_RX_PARITY_EN
    send_word(16'h0003, 0, 0, 0, 1, 1, 0);
    cmp("t6_perr0", 32'(parity_err), 32'h0);
    send_word(16'h0007, 0, 0, 0, 1, 1, 0);
    cmp("t6_perr1", 32'(parity_err), 32'h1);
    cmp("t6_data_out", 32'(data_out), 32'h0007);
    step(0, 0, 0, 0, 1);
`endif

    // Randomized traffic with random backpressure and occasional aborts
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, W - 1)) step(1, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), 0, pick(2));
        step(0, 0, 0, 1, pick(2));
      end
      send_word(W'($urandom), logic'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                $urandom_range(0, 2), 2, 2, logic'($urandom_range(0, 1)));
    end
    repeat (4) step(0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
